// File: rtl/edge_event_capture_pkg.sv
// Shared types and helpers for the edge event capture block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
`ifndef EDGE_EVENT_CAPTURE_PKG_SV
`define EDGE_EVENT_CAPTURE_PKG_SV

// Event record {data, rise, fall}, each W bits; data sits in the MSBs.
`define EEC_EVT_T(W) struct packed { logic [(W)-1:0] data; logic [(W)-1:0] rise; logic [(W)-1:0] fall; }

package edge_event_capture_pkg;

  // Pointer/count width for a DEPTH-entry queue: one extra MSB separates full from empty.
  function automatic int eec_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`endif

// File: rtl/edge_event_fifo.sv
// Generic DEPTH-entry synchronous FIFO, head read straight from storage at rd_ptr.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: head holds while pop_rdy=0; push is ignored when full unless a pop happens on the same edge.
module edge_event_fifo
  import edge_event_capture_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          push_vld,
  input  logic [WIDTH-1:0]              push_dat,
  output logic                          pop_vld,
  input  logic                          pop_rdy,
  output logic [WIDTH-1:0]              pop_dat,
  output logic                          full,
  output logic [eec_ptr_w(DEPTH)-1:0]   count
);

  localparam int PW = eec_ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;
  logic             push;

  // Pointers wrap naturally; their difference is the occupancy.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == PW'(DEPTH));
  assign pop_vld = (count != '0);
  assign pop     = pop_vld & pop_rdy;
  // When full, a simultaneous pop frees the slot being written this edge.
  assign push    = push_vld & (~full | pop);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; reset also clears storage so the head reads zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/edge_event_capture.sv
// Synchronizes an async bus, detects per-bit rise/fall, queues each change as an event.
// Latency: XIN stable across edge k gives EVT_VALID after edge k+SYNC_STAGES (empty queue).
// Backpressure: EVT_VALID/EVT_READY drain; a change arriving while full and not popping is dropped and flags OVERFLOW.
module edge_event_capture
  import edge_event_capture_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [WIDTH-1:0]              XIN,
  output logic                          EVT_VALID,
  input  logic                          EVT_READY,
  output logic [WIDTH-1:0]              EVT_DATA,
  output logic [WIDTH-1:0]              EVT_RISE,
  output logic [WIDTH-1:0]              EVT_FALL,
  output logic [eec_ptr_w(DEPTH)-1:0]   COUNT,
  output logic                          OVERFLOW,
  input  logic                          CLR_OVF
);

  typedef `EEC_EVT_T(WIDTH) evt_t;

  logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill_q;
  logic [WIDTH-1:0]       sx;
  logic [WIDTH-1:0]       prev_q;
  logic                   primed_q;
  logic                   change;
  logic                   drop;
  logic                   fifo_full;
  evt_t                   new_evt;
  evt_t                   head_evt;

  assign sx = sync_q[SYNC_STAGES-1];

  // Synchronizer chain plus a fill marker that tracks when SX carries a post-reset sample.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      fill_q <= '0;
    end else begin
      sync_q[0] <= XIN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Priming: the first cycle SX holds a real sample seeds prev without an event,
  // so a value already present on XIN through reset is never reported as a change.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      if (primed_q | fill_q[SYNC_STAGES-1]) begin
        prev_q <= sx;
      end
      if (fill_q[SYNC_STAGES-1]) begin
        primed_q <= 1'b1;
      end
    end
  end

  assign change       = primed_q & (sx != prev_q);
  assign new_evt.data = sx;
  assign new_evt.rise = sx & ~prev_q;
  assign new_evt.fall = ~sx & prev_q;

  // An event is lost only when the queue is full and nothing leaves on this edge.
  assign drop = change & fifo_full & ~(EVT_VALID & EVT_READY);

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OVERFLOW <= 1'b0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
    end else if (CLR_OVF) begin
      OVERFLOW <= 1'b0;
    end
  end

  edge_event_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .push_vld (change),
    .push_dat (new_evt),
    .pop_vld  (EVT_VALID),
    .pop_rdy  (EVT_READY),
    .pop_dat  (head_evt),
    .full     (fifo_full),
    .count    (COUNT)
  );

  assign EVT_DATA = head_evt.data;
  assign EVT_RISE = head_evt.rise;
  assign EVT_FALL = head_evt.fall;

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed bench for edge_event_capture: per-cycle vector table plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_edge_event_capture;

  logic       CLK;
  logic       RESET;
  logic [7:0] XIN;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [7:0] EVT_DATA;
  logic [7:0] EVT_RISE;
  logic [7:0] EVT_FALL;
  logic [2:0] COUNT;
  logic       OVERFLOW;
  logic       CLR_OVF;

  int checks   = 0;
  int failures = 0;

  edge_event_capture #(
    .WIDTH       (8),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .XIN       (XIN),
    .EVT_VALID (EVT_VALID),
    .EVT_READY (EVT_READY),
    .EVT_DATA  (EVT_DATA),
    .EVT_RISE  (EVT_RISE),
    .EVT_FALL  (EVT_FALL),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .CLR_OVF   (CLR_OVF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required finish before 2000000");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rst;
    logic [7:0] xin;
    logic       rdy;
    logic       clr;
    logic       chk_head;
    logic       vld;
    logic [2:0] cnt;
    logic [7:0] data;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [7:0] xin, input logic rdy,
                              input logic chk_head, input logic vld, input logic [2:0] cnt,
                              input logic [7:0] data, input logic [7:0] rise,
                              input logic [7:0] fall);
    vec_t v;
    v.rst = rst; v.xin = xin; v.rdy = rdy; v.clr = 1'b0; v.chk_head = chk_head;
    v.vld = vld; v.cnt = cnt; v.data = data; v.rise = rise; v.fall = fall; v.ovf = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: inputs already driven, sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    XIN = v;
    repeat (n) step();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  task automatic pop_one();
    EVT_READY = 1'b1;
    step();
    EVT_READY = 1'b0;
  endtask

  initial begin
    RESET     = 1'b1;
    XIN       = 8'h00;
    EVT_READY = 1'b0;
    CLR_OVF   = 1'b0;

    // ---------------- table: reset, latency, priming ----------------
    tbl.push_back(mk(1, 8'h00, 0, 1, 0, 3'd0, 8'h00, 8'h00, 8'h00));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h0F, 0, 0, 0, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h0F, 0, 0, 0, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h0F, 0, 1, 1, 3'd1, 8'h0F, 8'h0F, 8'h00));
    tbl.push_back(mk(0, 8'h0F, 1, 0, 0, 3'd0, 0, 0, 0));
    // value present through reset must not become an event
    tbl.push_back(mk(1, 8'hA5, 0, 1, 0, 3'd0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(1, 8'hA5, 0, 1, 0, 3'd0, 8'h00, 8'h00, 8'h00));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 8'hA5, 0, 0, 0, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h5A, 0, 0, 0, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h5A, 0, 0, 0, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h5A, 0, 1, 1, 3'd1, 8'h5A, 8'h5A, 8'hA5));
    tbl.push_back(mk(0, 8'h5A, 1, 0, 0, 3'd0, 0, 0, 0));
    // READY with nothing queued is ignored
    tbl.push_back(mk(0, 8'h5A, 1, 0, 0, 3'd0, 0, 0, 0));

    foreach (tbl[i]) begin
      RESET     = tbl[i].rst;
      XIN       = tbl[i].xin;
      EVT_READY = tbl[i].rdy;
      CLR_OVF   = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(EVT_VALID), 32'(tbl[i].vld));
      chk($sformatf("vec%0d_count", i), 32'(COUNT), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_ovf", i), 32'(OVERFLOW), 32'(tbl[i].ovf));
      if (tbl[i].chk_head) begin
        chk($sformatf("vec%0d_data", i), 32'(EVT_DATA), 32'(tbl[i].data));
        chk($sformatf("vec%0d_rise", i), 32'(EVT_RISE), 32'(tbl[i].rise));
        chk($sformatf("vec%0d_fall", i), 32'(EVT_FALL), 32'(tbl[i].fall));
      end
    end
    RESET = 1'b0; EVT_READY = 1'b0; CLR_OVF = 1'b0;

    // ---------------- overflow then ordered drain ----------------
    do_reset();
    hold(8'h00, 6);
    for (int v = 1; v <= 5; v++) hold(8'(v), 4);
    chk("ovf_fill_count", 32'(COUNT), 32'd4);
    chk("ovf_fill_flag", 32'(OVERFLOW), 32'd1);
    for (int v = 1; v <= 4; v++) begin
      logic [7:0] cur;
      logic [7:0] prv;
      cur = 8'(v);
      prv = 8'(v - 1);
      chk($sformatf("drain%0d_data", v), 32'(EVT_DATA), 32'(cur));
      chk($sformatf("drain%0d_rise", v), 32'(EVT_RISE), 32'(cur & ~prv));
      chk($sformatf("drain%0d_fall", v), 32'(EVT_FALL), 32'(~cur & prv));
      pop_one();
    end
    chk("drain_empty", 32'(EVT_VALID), 32'd0);
    hold(8'h06, 3);
    chk("after_drop_valid", 32'(EVT_VALID), 32'd1);
    chk("after_drop_data", 32'(EVT_DATA), 32'h06);
    chk("after_drop_rise", 32'(EVT_RISE), 32'h02);
    chk("after_drop_fall", 32'(EVT_FALL), 32'h01);
    pop_one();

    // ---------------- push and pop together while full ----------------
    do_reset();
    hold(8'h00, 6);
    hold(8'h10, 4); hold(8'h20, 4); hold(8'h30, 4); hold(8'h40, 4);
    chk("full_count", 32'(COUNT), 32'd4);
    XIN = 8'h50;
    step();
    step();
    EVT_READY = 1'b1;
    step();
    EVT_READY = 1'b0;
    chk("pushpop_count", 32'(COUNT), 32'd4);
    chk("pushpop_ovf", 32'(OVERFLOW), 32'd0);
    chk("pushpop_head", 32'(EVT_DATA), 32'h20);
    for (int v = 2; v <= 5; v++) begin
      chk($sformatf("pp_drain%0d", v), 32'(EVT_DATA), 32'(8'(v * 16)));
      pop_one();
    end
    chk("pp_empty", 32'(COUNT), 32'd0);

    // ---------------- CLR_OVF alone, then CLR_OVF colliding with a drop ----------------
    hold(8'h51, 4); hold(8'h52, 4); hold(8'h53, 4); hold(8'h54, 4);
    hold(8'h55, 4);
    chk("clr_pre_ovf", 32'(OVERFLOW), 32'd1);
    CLR_OVF = 1'b1;
    step();
    CLR_OVF = 1'b0;
    chk("clr_clears", 32'(OVERFLOW), 32'd0);
    XIN = 8'h56;
    step();
    step();
    CLR_OVF = 1'b1;
    step();
    CLR_OVF = 1'b0;
    chk("clr_vs_drop", 32'(OVERFLOW), 32'd1);
    chk("clr_vs_drop_count", 32'(COUNT), 32'd4);

    // ---------------- reset mid-operation discards queue and re-primes ----------------
    do_reset();
    hold(8'h00, 6);
    hold(8'h01, 4); hold(8'h02, 4); hold(8'h03, 4);
    chk("mid_pre_count", 32'(COUNT), 32'd3);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("mid_rst_valid", 32'(EVT_VALID), 32'd0);
    chk("mid_rst_count", 32'(COUNT), 32'd0);
    chk("mid_rst_ovf", 32'(OVERFLOW), 32'd0);
    hold(8'h03, 6);
    chk("reprime_count", 32'(COUNT), 32'd0);
    hold(8'h07, 3);
    chk("reprime_count1", 32'(COUNT), 32'd1);
    chk("reprime_data", 32'(EVT_DATA), 32'h07);
    chk("reprime_rise", 32'(EVT_RISE), 32'h04);
    chk("reprime_fall", 32'(EVT_FALL), 32'h00);
    hold(8'h07, 5);
    chk("reprime_only", 32'(COUNT), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
